// File: rtl/branch_stack.sv
// ---------------------------------------------------------------------------
// branch_stack
//
// Branch checkpoint store for the R10K out-of-order core. Dispatch writes one
// checkpoint per predicted branch (map table, free list, ROB tail, parent
// branch mask, recovery PC). The block tracks which branch-mask bits are live.
// It broadcasts each branch resolution. On a mispredict it drives the restore
// bundle consumed by Dispatch, the free list, the ROB and fetch.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   bs_alloc_mask           checkpoint slots Dispatch allocates this cycle
//   branch_stack_entries    flattened per-slot checkpoint packets, slot i at
//                           [i*ENTRY_W +: ENTRY_W], packed as
//                           {recovery_pc, rob_tail, free_list, map_table, b_m}
//   retire_free_mask        physical registers freed by retirement this cycle
//   resolve_valid/_mask/_mispredict/_target_pc
//                           branch resolution from execute (one-hot mask)
//   b_mask_combinational    live mask after this cycle's resolution
//   bs_full                 every checkpoint slot live
//   resolved_mask           bit to clear downstream on a correct prediction
//   squash_mask             resolving bit plus all live younger bits on mispredict
//   restore_valid           mispredict restore this cycle
//   map_table_restore, free_list_restore, rob_tail_restore, restore_pc
//                           restore bundle taken from the mispredicted checkpoint
// ---------------------------------------------------------------------------
module branch_stack #(
   parameter int B_MASK_WIDTH = 4,
   parameter int ARCH_REG_SZ  = 32,
   parameter int PHYS_REG_SZ  = 64,
   parameter int ROB_SZ       = 32,
   parameter int ADDR_W       = 32,
   localparam int PHYS_REG_IDX = $clog2(PHYS_REG_SZ),
   localparam int ROB_IDX_W    = $clog2(ROB_SZ),
   localparam int MAP_W        = ARCH_REG_SZ * PHYS_REG_IDX,
   localparam int ENTRY_W      = ADDR_W + ROB_IDX_W + PHYS_REG_SZ + MAP_W + B_MASK_WIDTH
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [B_MASK_WIDTH-1:0]          bs_alloc_mask,
   input  logic [B_MASK_WIDTH*ENTRY_W-1:0]  branch_stack_entries,
   input  logic [PHYS_REG_SZ-1:0]           retire_free_mask,
   input  logic                             resolve_valid,
   input  logic [B_MASK_WIDTH-1:0]          resolve_mask,
   input  logic                             resolve_mispredict,
   input  logic [ADDR_W-1:0]                resolve_target_pc,
   output logic [B_MASK_WIDTH-1:0]          b_mask_combinational,
   output logic                             bs_full,
   output logic [B_MASK_WIDTH-1:0]          resolved_mask,
   output logic [B_MASK_WIDTH-1:0]          squash_mask,
   output logic                             restore_valid,
   output logic [MAP_W-1:0]                 map_table_restore,
   output logic [PHYS_REG_SZ-1:0]           free_list_restore,
   output logic [ROB_IDX_W-1:0]             rob_tail_restore,
   output logic [ADDR_W-1:0]                restore_pc
);

   typedef struct packed {
      logic [ADDR_W-1:0]       recovery_pc;
      logic [ROB_IDX_W-1:0]    rob_tail;
      logic [PHYS_REG_SZ-1:0]  free_list;
      logic [MAP_W-1:0]        map_table;
      logic [B_MASK_WIDTH-1:0] b_m;
   } bs_entry_t;

   logic [B_MASK_WIDTH-1:0] b_mask_q, b_mask_d;
   bs_entry_t               entry_q [B_MASK_WIDTH];
   bs_entry_t               entry_d [B_MASK_WIDTH];

   // Resolution decode
   logic [B_MASK_WIDTH-1:0] hit_vec;
   logic                    res_hit;
   logic                    is_correct;
   logic                    is_mispredict;
   logic [B_MASK_WIDTH-1:0] b_mask_comb;

   // Fields of the checkpoint addressed by resolve_mask
   logic [ROB_IDX_W-1:0]    sel_rob_tail;
   logic [PHYS_REG_SZ-1:0]  sel_free_list;
   logic [MAP_W-1:0]        sel_map_table;
   logic [B_MASK_WIDTH-1:0] sel_b_m;

   logic [B_MASK_WIDTH-1:0] accept;

   // ------------------------------------------------------------------------
   // Resolution: combinational from resolve inputs and current state.
   // A resolution that does not hit a live bit is ignored entirely.
   // ------------------------------------------------------------------------
   always_comb begin
      hit_vec       = resolve_mask & b_mask_q;
      res_hit       = resolve_valid & (|hit_vec);
      is_correct    = res_hit & ~resolve_mispredict;
      is_mispredict = res_hit & resolve_mispredict;

      // resolve_mask is one-hot, so an OR-reduction acts as a mux.
      sel_rob_tail  = '0;
      sel_free_list = '0;
      sel_map_table = '0;
      sel_b_m       = '0;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
         if (hit_vec[i]) begin
            sel_rob_tail  = sel_rob_tail  | entry_q[i].rob_tail;
            sel_free_list = sel_free_list | entry_q[i].free_list;
            sel_map_table = sel_map_table | entry_q[i].map_table;
            sel_b_m       = sel_b_m       | entry_q[i].b_m;
         end
      end

      b_mask_comb = b_mask_q;
      if (is_correct) begin
         b_mask_comb = b_mask_q & ~resolve_mask;
      end else if (is_mispredict) begin
         // The checkpoint's parent mask is exactly the set of older live branches.
         b_mask_comb = sel_b_m;
      end
   end

   always_comb begin
      b_mask_combinational = b_mask_comb;
      bs_full              = &b_mask_comb;
      resolved_mask        = is_correct ? resolve_mask : '0;
      squash_mask          = is_mispredict ? (b_mask_q & ~sel_b_m) : '0;
      restore_valid        = is_mispredict;
      map_table_restore    = is_mispredict ? sel_map_table : '0;
      // Registers retired this cycle are not yet in the checkpoint, so merge them here.
      free_list_restore    = is_mispredict ? (sel_free_list | retire_free_mask) : '0;
      rob_tail_restore     = is_mispredict ? sel_rob_tail : '0;
      restore_pc           = is_mispredict ? resolve_target_pc : '0;
   end

   // ------------------------------------------------------------------------
   // Next state: surviving entries absorb retirements and drop a correctly
   // resolved parent bit; free slots accept new checkpoints unless a
   // mispredict is restoring this cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      accept = '0;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
         entry_d[i] = entry_q[i];
         if (b_mask_comb[i]) begin
            entry_d[i].free_list = entry_q[i].free_list | retire_free_mask;
            if (is_correct) begin
               entry_d[i].b_m = entry_q[i].b_m & ~resolve_mask;
            end
         end
         if (bs_alloc_mask[i] && !b_mask_comb[i] && !is_mispredict) begin
            accept[i]            = 1'b1;
            entry_d[i]           = branch_stack_entries[i*ENTRY_W +: ENTRY_W];
            // Dispatch's snapshot misses retirements of the allocating cycle.
            entry_d[i].free_list = entry_d[i].free_list | retire_free_mask;
         end
      end
      b_mask_d = b_mask_comb | accept;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         b_mask_q <= '0;
         for (int i = 0; i < B_MASK_WIDTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         b_mask_q <= b_mask_d;
         for (int i = 0; i < B_MASK_WIDTH; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

endmodule

// File: tb/tb_branch_stack.sv
module tb_branch_stack;

   localparam int BW      = 4;
   localparam int MAP_W   = 32 * 6;
   localparam int ENTRY_W = 32 + 5 + 64 + MAP_W + BW;
   localparam logic [63:0] FL     = 64'h0000_00FF_0000_00FF;
   localparam logic [31:0] TGT_PC = 32'hABCD_0010;

   logic                   clock;
   logic                   reset;
   logic [BW-1:0]          bs_alloc_mask;
   logic [BW*ENTRY_W-1:0]  branch_stack_entries;
   logic [63:0]            retire_free_mask;
   logic                   resolve_valid;
   logic [BW-1:0]          resolve_mask;
   logic                   resolve_mispredict;
   logic [31:0]            resolve_target_pc;
   logic [BW-1:0]          b_mask_combinational;
   logic                   bs_full;
   logic [BW-1:0]          resolved_mask;
   logic [BW-1:0]          squash_mask;
   logic                   restore_valid;
   logic [MAP_W-1:0]       map_table_restore;
   logic [63:0]            free_list_restore;
   logic [4:0]             rob_tail_restore;
   logic [31:0]            restore_pc;

   branch_stack dut (
      .clock                (clock),
      .reset                (reset),
      .bs_alloc_mask        (bs_alloc_mask),
      .branch_stack_entries (branch_stack_entries),
      .retire_free_mask     (retire_free_mask),
      .resolve_valid        (resolve_valid),
      .resolve_mask         (resolve_mask),
      .resolve_mispredict   (resolve_mispredict),
      .resolve_target_pc    (resolve_target_pc),
      .b_mask_combinational (b_mask_combinational),
      .bs_full              (bs_full),
      .resolved_mask        (resolved_mask),
      .squash_mask          (squash_mask),
      .restore_valid        (restore_valid),
      .map_table_restore    (map_table_restore),
      .free_list_restore    (free_list_restore),
      .rob_tail_restore     (rob_tail_restore),
      .restore_pc           (restore_pc)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [MAP_W-1:0] mk_map(input logic [4:0] tail);
      logic [MAP_W-1:0] m;
      m = '0;
      for (int r = 0; r < 32; r++) m[r*6 +: 6] = 6'(r + 3 * tail);
      return m;
   endfunction

   function automatic logic [ENTRY_W-1:0] mk_entry(input logic [4:0] tail, input logic [BW-1:0] bm);
      return {32'h4000_0000 | 32'(tail), tail, FL, mk_map(tail), bm};
   endfunction

   // Allocated slots get the described checkpoint; others get junk that must never land.
   task automatic drive_alloc(input logic [BW-1:0] am, input logic [4:0] tail, input logic [BW-1:0] bm);
      bs_alloc_mask = am;
      for (int i = 0; i < BW; i++)
         branch_stack_entries[i*ENTRY_W +: ENTRY_W] = am[i] ? mk_entry(tail, bm) : mk_entry(5'd31, 4'hF);
   endtask

   task automatic drive_resolve(input logic rv, input logic [BW-1:0] rm, input logic mp);
      resolve_valid      = rv;
      resolve_mask       = rm;
      resolve_mispredict = mp;
   endtask

   typedef struct packed {
      logic [3:0] alloc;
      logic [3:0] bm;
      logic [4:0] tail;
      logic       rv;
      logic [3:0] rm;
      logic       mp;
      logic [3:0] e_bmc;
      logic       e_full;
      logic [3:0] e_res;
      logic [3:0] e_sq;
      logic       e_rst;
      logic [4:0] e_tail;
   } vec_t;

   vec_t vecs [22];

   initial begin
      //            alloc    bm       tail   rv    rm       mp    e_bmc    full  e_res    e_sq     rst   e_tail
      vecs[0]  = '{4'b0001, 4'b0000, 5'd5,  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[1]  = '{4'b0000, 4'b0000, 5'd0,  1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[2]  = '{4'b0010, 4'b0001, 5'd9,  1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[3]  = '{4'b0000, 4'b0000, 5'd0,  1'b1, 4'b0001, 1'b0, 4'b0010, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'd0};
      vecs[4]  = '{4'b0000, 4'b0000, 5'd0,  1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 5'd9};
      vecs[5]  = '{4'b0001, 4'b0000, 5'd3,  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[6]  = '{4'b0010, 4'b0001, 5'd7,  1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[7]  = '{4'b0100, 4'b0011, 5'd11, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[8]  = '{4'b0000, 4'b0000, 5'd0,  1'b1, 4'b0010, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0110, 1'b1, 5'd7};
      vecs[9]  = '{4'b0100, 4'b0001, 5'd13, 1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1, 5'd3};
      vecs[10] = '{4'b0000, 4'b0000, 5'd0,  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[11] = '{4'b0000, 4'b0000, 5'd0,  1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[12] = '{4'b0001, 4'b0000, 5'd1,  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[13] = '{4'b0010, 4'b0001, 5'd2,  1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[14] = '{4'b0100, 4'b0011, 5'd4,  1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[15] = '{4'b1000, 4'b0111, 5'd6,  1'b0, 4'b0000, 1'b0, 4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[16] = '{4'b0000, 4'b0000, 5'd0,  1'b0, 4'b0000, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[17] = '{4'b0001, 4'b1111, 5'd30, 1'b0, 4'b0000, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[18] = '{4'b1000, 4'b0111, 5'd20, 1'b1, 4'b1000, 1'b0, 4'b0111, 1'b0, 4'b1000, 4'b0000, 1'b0, 5'd0};
      vecs[19] = '{4'b0000, 4'b0000, 5'd0,  1'b0, 4'b0000, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'd0};
      vecs[20] = '{4'b0000, 4'b0000, 5'd0,  1'b1, 4'b1000, 1'b1, 4'b0111, 1'b0, 4'b0000, 4'b1000, 1'b1, 5'd20};
      vecs[21] = '{4'b0000, 4'b0000, 5'd0,  1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0111, 1'b1, 5'd1};

      reset             = 1'b1;
      retire_free_mask  = '0;
      resolve_target_pc = TGT_PC;
      drive_alloc(4'b0000, 5'd0, 4'b0000);
      drive_resolve(1'b0, 4'b0000, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #2;
      check("reset_bmc",     b_mask_combinational, 4'b0000);
      check("reset_full",    bs_full,              1'b0);
      check("reset_restore", restore_valid,        1'b0);
      check("reset_squash",  squash_mask,          4'b0000);
      check("reset_flr",     free_list_restore,    64'h0);

      for (int v = 0; v < 22; v++) begin
         @(negedge clock);
         drive_alloc(vecs[v].alloc, vecs[v].tail, vecs[v].bm);
         drive_resolve(vecs[v].rv, vecs[v].rm, vecs[v].mp);
         #2;
         check($sformatf("v%0d_bmc", v),      b_mask_combinational, vecs[v].e_bmc);
         check($sformatf("v%0d_full", v),     bs_full,              vecs[v].e_full);
         check($sformatf("v%0d_resolved", v), resolved_mask,        vecs[v].e_res);
         check($sformatf("v%0d_squash", v),   squash_mask,          vecs[v].e_sq);
         check($sformatf("v%0d_restore", v),  restore_valid,        vecs[v].e_rst);
         check($sformatf("v%0d_robtail", v),  rob_tail_restore,     vecs[v].e_tail);
         check($sformatf("v%0d_map", v),      map_table_restore,    vecs[v].e_rst ? mk_map(vecs[v].e_tail) : '0);
         check($sformatf("v%0d_flr", v),      free_list_restore,    vecs[v].e_rst ? FL : 64'h0);
         check($sformatf("v%0d_pc", v),       restore_pc,           vecs[v].e_rst ? TGT_PC : 32'h0);
      end

      // Free-list: retirements in the allocating cycle, two cycles later and in the restore cycle all survive.
      @(negedge clock);
      drive_alloc(4'b0001, 5'd8, 4'b0000);
      drive_resolve(1'b0, 4'b0000, 1'b0);
      retire_free_mask = 64'h1 << 10;
      @(negedge clock);
      drive_alloc(4'b0000, 5'd0, 4'b0000);
      retire_free_mask = '0;
      @(negedge clock);
      retire_free_mask = 64'h1 << 40;
      @(negedge clock);
      retire_free_mask = 64'h1 << 50;
      drive_resolve(1'b1, 4'b0001, 1'b1);
      #2;
      check("fl_restore_valid", restore_valid, 1'b1);
      check("fl_bit40",         free_list_restore[40], 1'b1);
      check("fl_full",          free_list_restore, FL | (64'h1 << 10) | (64'h1 << 40) | (64'h1 << 50));
      check("fl_robtail",       rob_tail_restore, 5'd8);

      // Reset mid-run wins over simultaneous allocate and resolve.
      @(negedge clock);
      retire_free_mask = '0;
      drive_resolve(1'b0, 4'b0000, 1'b0);
      drive_alloc(4'b0001, 5'd12, 4'b0000);
      @(negedge clock);
      drive_alloc(4'b0010, 5'd14, 4'b0001);
      @(negedge clock);
      #2;
      check("pre_reset_bmc", b_mask_combinational, 4'b0011);
      reset = 1'b1;
      drive_alloc(4'b0100, 5'd16, 4'b0011);
      drive_resolve(1'b1, 4'b0001, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      drive_alloc(4'b0000, 5'd0, 4'b0000);
      drive_resolve(1'b1, 4'b0001, 1'b1);
      #2;
      check("post_reset_bmc",     b_mask_combinational, 4'b0000);
      check("post_reset_full",    bs_full,              1'b0);
      check("post_reset_restore", restore_valid,        1'b0);
      check("post_reset_squash",  squash_mask,          4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
